actuator_driver: RTL and testbench
==================================

Name: actuator_driver

Overview:
- Downstream stage of the incubator climate controller: consumes its cooler/heater requests and 4-bit fan speed code, and drives the physical actuators.
- Generates a fan PWM with a soft-start/soft-stop ramp toward the requested level.
- Enforces a heater/cooler interlock: never both on, with a dead-time gap on every changeover.
- Flags a fault when both requests are asserted at once.

Parameters:
PWM_DIV, 4, clk cycles per PWM tick (>=1)
RAMP_PERIODS, 8, full PWM periods between successive 1-step fan level changes (>=1)
DEAD_TIME, 16, clk cycles with both actuators off on any heater/cooler changeover (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cooler_req  input  1  cooler request from controller
heater_req  input  1  heater request from controller
fan_req  input  4  requested fan level 0..15 (controller issues 0/4/6/8)
cooler_en  output  1  cooler drive
heater_en  output  1  heater drive
fan_pwm  output  1  fan PWM drive
fan_level  output  4  current ramped fan level
fault  output  1  both requests asserted simultaneously

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM=IDLE; prescaler, pwm_phase, ramp_cnt, dead_cnt and fan_level all 0. First state change occurs on the first clk edge after rst goes high.
- Prescaler:
  - Counts 0..PWM_DIV-1 and wraps.
  - tick=1 in the cycle where prescaler==PWM_DIV-1.
- PWM:
  - pwm_phase is 4 bits and increments on tick, wrapping 15->0. A PWM period is 16 ticks.
  - fan_pwm is registered: fan_pwm <= (pwm_phase < fan_level), evaluated every clk.
  - Level 0 gives constant 0. Level L gives L/16 duty. Level 15 gives 15/16 duty; 100% is never reached.
- Ramp:
  - period_end = tick && pwm_phase==15.
  - On period_end, ramp_cnt increments. When ramp_cnt==RAMP_PERIODS-1, ramp_cnt clears and fan_level steps once toward fan_req: +1 if below, -1 if above, hold if equal.
  - fan_level changes only at period boundaries, so there is no glitch mid-period.
  - fan_req may change at any time. Only its value at the step instant matters, and the ramp reverses direction without restart.
- Interlock FSM, states IDLE, COOL, HEAT, DEAD:
  - IDLE: cooler_req&~heater_req -> COOL; heater_req&~cooler_req -> HEAT; otherwise stay.
  - COOL: if ~cooler_req or heater_req -> DEAD, loading dead_cnt=DEAD_TIME-1.
  - HEAT: if ~heater_req or cooler_req -> DEAD, loading dead_cnt=DEAD_TIME-1.
  - DEAD: dead_cnt decrements each clk; at dead_cnt==0 -> IDLE. Requests are ignored while in DEAD.
- Actuator outputs:
  - cooler_en = (state==COOL); heater_en = (state==HEAT). Both are decoded from registered state, so never both 1.
  - Latency: a request sampled at edge k gives enable high after edge k (1 cycle).
  - Deassertion: enable falls after the edge on which the request is seen low.
  - Changeover COOL->HEAT: DEAD lasts exactly DEAD_TIME cycles, then 1 cycle in IDLE, then HEAT. heater_en rises DEAD_TIME+1 edges after cooler_en falls. HEAT->COOL is symmetric.
  - Both requests high in IDLE: stay IDLE, no enable.
- Fault:
  - Registered: fault <= cooler_req&heater_req. Clears the cycle after either request drops.
  - Does not affect the fan.
- Independence: the fan ramp is independent of the FSM. The controller zeroes fan_req when not cooling, and the ramp then winds fan_level down to 0.
- Reset mid-operation: immediate return to the reset values above. In-progress ramp and dead-time are discarded.

Test Plan:
(All with PWM_DIV=2, RAMP_PERIODS=1, DEAD_TIME=4.)
1. Reset then cooler_req=1 -> cooler_en=1 after 1 edge, heater_en=0, fault=0.
2. Fan ramp: fan_req 0->8 -> fan_level steps 1,2,...,8, one step per 32 clk (one PWM period). Holds at 8. At level 8, fan_pwm high 16 clk / low 16 clk per period.
3. Ramp reversal: fan_req=8 while at level 5, then fan_req=0 at level 7 -> level goes 8 or 7 per boundary timing, then decrements to 0. Level 0 gives fan_pwm constantly 0.
4. Changeover: in COOL, drop cooler_req and raise heater_req on the same edge -> cooler_en falls on that edge; both enables 0 for exactly 5 cycles (4 DEAD + 1 IDLE); heater_en=1 on the following edge.
5. Both requests=1 from IDLE -> fault=1 next cycle, no enable. Drop heater_req -> fault=0 next cycle; cooler_en=1 next cycle.
6. Assert rst=0 asynchronously mid-DEAD with fan_level=6 -> all outputs 0 immediately without a clk edge. After release, behaviour is identical to a fresh reset.

Source files
------------

// File: rtl/actuator_driver.sv
`default_nettype none
// ============================================================================
// Module   : actuator_driver
// Purpose  : Drives cooler/heater/fan actuators for the incubator climate
//            controller. Fan PWM with a soft ramp toward the requested level,
//            heater/cooler interlock with dead time, dual-request fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module actuator_driver #(
  parameter int PWM_DIV      = 4,
  parameter int RAMP_PERIODS = 8,
  parameter int DEAD_TIME    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cooler_req,
  input  logic       heater_req,
  input  logic [3:0] fan_req,
  output logic       cooler_en,
  output logic       heater_en,
  output logic       fan_pwm,
  output logic [3:0] fan_level,
  output logic       fault
);

  // Counter widths are held at a minimum of 1 bit so a parameter of 1 still
  // yields a legal (always-zero) counter.
  localparam int PW = (PWM_DIV > 1)      ? $clog2(PWM_DIV)      : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int DW = (DEAD_TIME > 1)    ? $clog2(DEAD_TIME)    : 1;

  localparam logic [PW-1:0] C_PRESC_LAST = PW'(PWM_DIV - 1);
  localparam logic [RW-1:0] C_RAMP_LAST  = RW'(RAMP_PERIODS - 1);
  localparam logic [DW-1:0] C_DEAD_LOAD  = DW'(DEAD_TIME - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COOL = 2'd1,
    HEAT = 2'd2,
    DEAD = 2'd3
  } state_t;

  logic [PW-1:0] presc_q;
  logic [3:0]    pwm_phase_q;
  logic [RW-1:0] ramp_cnt_q;
  logic [3:0]    fan_level_q;
  logic          fan_pwm_q;
  logic          fault_q;
  state_t        state_q, state_d;
  logic [DW-1:0] dead_q, dead_d;

  logic tick;
  logic period_end;

  assign tick       = (presc_q == C_PRESC_LAST);
  assign period_end = tick && (pwm_phase_q == 4'd15);

  // Prescaler: free-running divide-by-PWM_DIV producing the PWM tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  // PWM phase advances once per tick; 16 ticks form one PWM period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pwm_phase_q <= 4'd0;
    else if (tick) pwm_phase_q <= pwm_phase_q + 4'd1;
  end

  // Registered PWM compare; level 15 still leaves one low phase per period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fan_pwm_q <= 1'b0;
    else      fan_pwm_q <= (pwm_phase_q < fan_level_q);
  end

  // Soft ramp: one level step toward fan_req every RAMP_PERIODS periods,
  // only at a period boundary so the duty never glitches mid-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ramp_cnt_q  <= '0;
      fan_level_q <= 4'd0;
    end else if (period_end) begin
      if (ramp_cnt_q == C_RAMP_LAST) begin
        ramp_cnt_q <= '0;
        if (fan_level_q < fan_req)      fan_level_q <= fan_level_q + 4'd1;
        else if (fan_level_q > fan_req) fan_level_q <= fan_level_q - 4'd1;
      end else begin
        ramp_cnt_q <= ramp_cnt_q + 1'b1;
      end
    end
  end

  // Interlock state and dead-time counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
    end
  end

  // Interlock next-state: every changeover passes through DEAD then IDLE.
  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        if (cooler_req && !heater_req)      state_d = COOL;
        else if (heater_req && !cooler_req) state_d = HEAT;
      end
      COOL: begin
        if (!cooler_req || heater_req) begin
          state_d = DEAD;
          dead_d  = C_DEAD_LOAD;
        end
      end
      HEAT: begin
        if (!heater_req || cooler_req) begin
          state_d = DEAD;
          dead_d  = C_DEAD_LOAD;
        end
      end
      DEAD: begin
        if (dead_q == '0) state_d = IDLE;
        else              dead_d  = dead_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fault flag: registered coincidence of both requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= cooler_req && heater_req;
  end

  assign cooler_en = (state_q == COOL);
  assign heater_en = (state_q == HEAT);
  assign fan_pwm   = fan_pwm_q;
  assign fan_level = fan_level_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_actuator_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_actuator_driver
// Purpose  : Self-checking bench for actuator_driver with a behavioural
//            reference model and directed plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_actuator_driver;

  localparam int PWM_DIV      = 2;
  localparam int RAMP_PERIODS = 1;
  localparam int DEAD_TIME    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cooler_req, heater_req;
  logic [3:0] fan_req;
  logic       cooler_en, heater_en, fan_pwm, fault;
  logic [3:0] fan_level;

  int checks = 0;
  int errors = 0;

  actuator_driver #(
    .PWM_DIV      (PWM_DIV),
    .RAMP_PERIODS (RAMP_PERIODS),
    .DEAD_TIME    (DEAD_TIME)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cooler_req (cooler_req),
    .heater_req (heater_req),
    .fan_req    (fan_req),
    .cooler_en  (cooler_en),
    .heater_en  (heater_en),
    .fan_pwm    (fan_pwm),
    .fan_level  (fan_level),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int m_edges   = 0;  // clock edges since reset release
  int m_periods = 0;  // completed PWM periods since reset release
  int m_level   = 0;
  bit m_pwm     = 0;
  bit m_fault   = 0;
  bit m_cool    = 0;
  bit m_heat    = 0;
  int m_gap     = 0;  // remaining forced-off cycles before requests count again

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edges = 0; m_periods = 0; m_level = 0; m_pwm = 0; m_fault = 0;
      m_cool = 0; m_heat = 0; m_gap = 0;
    end else begin
      int phase;
      bit pend;
      phase = (m_edges / PWM_DIV) % 16;
      pend  = ((m_edges % PWM_DIV) == PWM_DIV - 1) && (phase == 15);
      m_pwm = (phase < m_level);
      if (pend) begin
        m_periods++;
        if (m_periods % RAMP_PERIODS == 0) begin
          if (m_level < int'(fan_req))      m_level++;
          else if (m_level > int'(fan_req)) m_level--;
        end
      end
      m_edges++;
      m_fault = cooler_req && heater_req;
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_cool) begin
        if (!cooler_req || heater_req) begin m_cool = 0; m_gap = DEAD_TIME; end
      end else if (m_heat) begin
        if (!heater_req || cooler_req) begin m_heat = 0; m_gap = DEAD_TIME; end
      end else begin
        if (cooler_req && !heater_req)      m_cool = 1;
        else if (heater_req && !cooler_req) m_heat = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int act, exp;
    act = {27'd0, cooler_en, heater_en, fan_pwm, fault} | (int'(fan_level) << 4);
    if (!rst) exp = 0;
    else exp = {27'd0, m_cool, m_heat, m_pwm, m_fault} | (m_level << 4);
    chk("model_cycle{lvl,cool,heat,pwm,fault}", act, exp);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input int lvl, input int budget, input string name);
    int n = 0;
    while (int'(fan_level) != lvl && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk(name, int'(fan_level), lvl);
  endtask

  initial begin
    int cnt;
    rst = 1'b0; cooler_req = 0; heater_req = 0; fan_req = 4'd0;
    #12;
    chk("reset_outputs", {cooler_en, heater_en, fan_pwm, fault, fan_level}, 0);
    @(negedge clk); rst = 1'b1;

    // 1: cooler request enables cooler one edge later
    @(negedge clk); cooler_req = 1;
    cyc(1);
    chk("t1_cooler_en", cooler_en, 1);
    chk("t1_heater_en", heater_en, 0);
    chk("t1_fault", fault, 0);

    // 2: ramp up to 8 and check 50% duty
    @(negedge clk); fan_req = 4'd8;
    wait_level(8, 9 * 32 + 8, "t2_ramp_to_8");
    cyc(2);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin cyc(1); cnt += int'(fan_pwm); end
    chk("t2_duty_high_of_32", cnt, 16);
    cyc(64);
    chk("t2_hold_8", fan_level, 8);

    // 3: ramp reversal down, up, then down to zero
    @(negedge clk); fan_req = 4'd0;
    wait_level(5, 5 * 32, "t3_down_to_5");
    @(negedge clk); fan_req = 4'd8;
    wait_level(7, 4 * 32, "t3_up_to_7");
    @(negedge clk); fan_req = 4'd0;
    wait_level(0, 10 * 32, "t3_down_to_0");
    cyc(2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); cnt += int'(fan_pwm); end
    chk("t3_pwm_zero_at_level0", cnt, 0);

    // 4: changeover cooler -> heater
    @(negedge clk); cooler_req = 0; heater_req = 1;
    cyc(1);
    chk("t4_cooler_falls", cooler_en, 0);
    cnt = 0;
    while (!heater_en && cnt < 20) begin
      chk("t4_both_off", {cooler_en, heater_en}, 0);
      cyc(1); cnt++;
    end
    chk("t4_edges_to_heat", cnt, DEAD_TIME + 1);

    // 5: both requests from IDLE
    @(negedge clk); heater_req = 0;
    cyc(DEAD_TIME + 3);
    @(negedge clk); cooler_req = 1; heater_req = 1;
    cyc(1);
    chk("t5_fault_set", fault, 1);
    cyc(3);
    chk("t5_no_enable", {cooler_en, heater_en}, 0);
    @(negedge clk); heater_req = 0;
    cyc(1);
    chk("t5_fault_clear", fault, 0);
    chk("t5_cooler_en", cooler_en, 1);

    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) {cooler_req, heater_req} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) fan_req = 4'($urandom_range(0, 15));
    end

    // 6: asynchronous reset in DEAD with fan at 6
    @(negedge clk); cooler_req = 1; heater_req = 0; fan_req = 4'd6;
    wait_level(6, 17 * 32, "t6_level_6");
    @(negedge clk); cooler_req = 0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_level", fan_level, 0);
    chk("t6_async_outs", {cooler_en, heater_en, fan_pwm, fault}, 0);
    cyc(3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); cooler_req = 1;
    cyc(1);
    chk("t6_fresh_cooler_en", cooler_en, 1);
    cyc(40);
    chk("t6_fresh_level_1", fan_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
